// File: rtl/parking_exit_gate_if.sv
// Exit-gate bundle: car/code inputs from the lane hardware and gate, LED,
// occupancy and display outputs.
//   slave  : the exit-gate controller (consumes inputs, drives outputs)
//   master : the driving side (lane hardware / testbench)
interface parking_exit_gate_if #(
    parameter int unsigned CNT_W = 7
) ();
    logic             entry_done;   // one-cycle pulse: a car completed entry
    logic             sensor_exit;  // car present at the exit gate (level)
    logic             code_valid;   // one-cycle strobe qualifying code_in
    logic [1:0]       code_in;      // exit code presented by driver
    logic             gate_open;    // barrier raise command
    logic             GREEN_LED;    // exit permitted
    logic             RED_LED;      // refused / waiting / locked
    logic [CNT_W-1:0] occupancy;    // cars currently in the lot
    logic             full;         // occupancy == CAPACITY
    logic             empty;        // occupancy == 0
    logic [6:0]       HEX_1;        // tens digit, active-low {g,f,e,d,c,b,a}
    logic [6:0]       HEX_2;        // units digit, same encoding

    modport slave (
        input  entry_done, sensor_exit, code_valid, code_in,
        output gate_open, GREEN_LED, RED_LED, occupancy, full, empty,
               HEX_1, HEX_2
    );

    modport master (
        output entry_done, sensor_exit, code_valid, code_in,
        input  gate_open, GREEN_LED, RED_LED, occupancy, full, empty,
               HEX_1, HEX_2
    );
endinterface

// File: rtl/parking_exit_gate.sv
// Parking lot exit-gate controller: keeps the occupancy count, runs the
// exit-code FSM and drives the gate, LEDs and 2-digit occupancy display.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : parking_exit_gate_if.slave (inputs entry_done, sensor_exit,
//             code_valid, code_in; outputs gate_open, GREEN_LED, RED_LED,
//             occupancy, full, empty, HEX_1, HEX_2). All outputs registered.
module parking_exit_gate #(
    parameter int unsigned CAPACITY    = 9,
    parameter int unsigned CNT_W       = 7,
    parameter logic [1:0]  EXIT_CODE   = 2'b10,
    parameter int unsigned PAY_TIMEOUT = 16,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 32
) (
    input logic                clk,
    input logic                reset_n,
    parking_exit_gate_if.slave bus
);
    localparam int unsigned TMR_MAX = (PAY_TIMEOUT > LOCK_CYCLES) ? PAY_TIMEOUT : LOCK_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        IDLE, WAIT_CODE, WRONG_CODE, LOCKOUT, OPEN, CLOSE
    } state_t;

    state_t           state, state_nx;
    logic [TRY_W-1:0] try_cnt, try_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0] occ, occ_nx, tens, units;
    logic             inc, dec, phantom;
    logic             gate_r, green_r, red_r, full_r, empty_r;
    logic             gate_nx, green_nx, red_nx;
    logic [6:0]       hex1_r, hex2_r;

    function automatic logic [6:0] seg7(input logic [CNT_W-1:0] d);
        logic [6:0] s;
        if (d > CNT_W'(9)) begin
            s = SEG_BLANK;
        end else begin
            case (d[3:0])
                4'd0:    s = 7'b1000000;
                4'd1:    s = 7'b1111001;
                4'd2:    s = 7'b0100100;
                4'd3:    s = 7'b0110000;
                4'd4:    s = 7'b0011001;
                4'd5:    s = 7'b0010010;
                4'd6:    s = 7'b0000010;
                4'd7:    s = 7'b1111000;
                4'd8:    s = 7'b0000000;
                4'd9:    s = 7'b0010000;
                default: s = SEG_BLANK;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        state_nx = state;
        try_nx   = try_cnt;
        timer_nx = timer;
        dec      = 1'b0;
        phantom  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sensor_exit) begin
                    if (!empty_r) begin
                        state_nx = WAIT_CODE;
                        timer_nx = '0;
                    end else begin
                        phantom = 1'b1;
                    end
                end
            end
            WAIT_CODE: begin
                timer_nx = timer + 1'b1;
                // A valid code outranks both sensor drop and timeout.
                if (bus.code_valid) begin
                    if (bus.code_in == EXIT_CODE) begin
                        state_nx = OPEN;
                    end else begin
                        state_nx = WRONG_CODE;
                        try_nx   = try_cnt + 1'b1;
                    end
                end else if (!bus.sensor_exit || timer == TMR_W'(PAY_TIMEOUT - 1)) begin
                    state_nx = IDLE;
                    try_nx   = '0;
                end
            end
            WRONG_CODE: begin
                timer_nx = '0;
                state_nx = (try_cnt == TRY_W'(MAX_TRIES)) ? LOCKOUT : WAIT_CODE;
            end
            LOCKOUT: begin
                if (timer == TMR_W'(LOCK_CYCLES - 1)) begin
                    state_nx = IDLE;
                    try_nx   = '0;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            OPEN: begin
                if (!bus.sensor_exit) begin
                    state_nx = CLOSE;
                    dec      = 1'b1;
                end
            end
            CLOSE: begin
                state_nx = IDLE;
                try_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase

        // Moore outputs are computed from the next state so they register
        // in step with it.
        gate_nx  = (state_nx == OPEN);
        green_nx = (state_nx == OPEN);
        case (state_nx)
            WAIT_CODE, WRONG_CODE: red_nx = 1'b1;
            LOCKOUT:               red_nx = timer_nx[0];
            IDLE:                  red_nx = phantom;
            default:               red_nx = 1'b0;
        endcase

        inc = bus.entry_done && !full_r;
        if (inc && !dec) begin
            occ_nx = occ + 1'b1;
        end else if (dec && !inc) begin
            occ_nx = occ - 1'b1;
        end else begin
            occ_nx = occ;
        end
        tens  = occ_nx / CNT_W'(10);
        units = occ_nx % CNT_W'(10);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            try_cnt <= '0;
            timer   <= '0;
            occ     <= '0;
            gate_r  <= 1'b0;
            green_r <= 1'b0;
            red_r   <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            hex1_r  <= 7'b1000000;
            hex2_r  <= 7'b1000000;
        end else begin
            state   <= state_nx;
            try_cnt <= try_nx;
            timer   <= timer_nx;
            occ     <= occ_nx;
            gate_r  <= gate_nx;
            green_r <= green_nx;
            red_r   <= red_nx;
            full_r  <= (occ_nx == CNT_W'(CAPACITY));
            empty_r <= (occ_nx == '0);
            hex1_r  <= seg7(tens);
            hex2_r  <= seg7(units);
        end
    end

    assign bus.gate_open = gate_r;
    assign bus.GREEN_LED = green_r;
    assign bus.RED_LED   = red_r;
    assign bus.occupancy = occ;
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.HEX_1     = hex1_r;
    assign bus.HEX_2     = hex2_r;
endmodule

// File: tb/tb_parking_exit_gate.sv
// Self-checking bench for parking_exit_gate. The driver issues one vector
// per cycle and queues the outputs expected after that clock edge; a
// monitor pops and compares one entry after every rising edge.
module tb_parking_exit_gate;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic       gate;
        logic       green;
        logic       red;
        logic       full;
        logic       empty;
        logic [6:0] occ;
        logic [6:0] hex1;
        logic [6:0] hex2;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t  exp_q[$];
    string nm_q[$];

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    parking_exit_gate_if #(.CNT_W(7)) bus ();

    parking_exit_gate #(
        .CAPACITY(9), .CNT_W(7), .EXIT_CODE(2'b10),
        .PAY_TIMEOUT(16), .MAX_TRIES(3), .LOCK_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic g, input logic gr, input logic r, input int unsigned o);
        exp_t e;
        e.gate  = g;
        e.green = gr;
        e.red   = r;
        e.full  = (o == 9);
        e.empty = (o == 0);
        e.occ   = 7'(o);
        e.hex1  = seg_tab[o / 10];
        e.hex2  = seg_tab[o % 10];
        return e;
    endfunction

    task automatic step(input logic rn, input logic en, input logic se, input logic cv,
                        input logic [1:0] code, input exp_t e, input string nm);
        @(negedge clk);
        reset_n         = rn;
        bus.entry_done  = en;
        bus.sensor_exit = se;
        bus.code_valid  = cv;
        bus.code_in     = code;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Monitor: compares the oldest queued expectation after each edge.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                a  = '{bus.gate_open, bus.GREEN_LED, bus.RED_LED, bus.full, bus.empty,
                       bus.occupancy, bus.HEX_1, bus.HEX_2};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL %s @%0t: got gate/grn/red/full/empty/occ/hex1/hex2=%b/%b/%b/%b/%b/%0d/%b/%b want %b/%b/%b/%b/%b/%0d/%b/%b",
                             nm, $time, a.gate, a.green, a.red, a.full, a.empty, a.occ, a.hex1, a.hex2,
                             e.gate, e.green, e.red, e.full, e.empty, e.occ, e.hex1, e.hex2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.entry_done  = 1'b0;
        bus.sensor_exit = 1'b0;
        bus.code_valid  = 1'b0;
        bus.code_in     = 2'b00;

        // Reset
        step(L, L, L, L, 2'b00, mk(L, L, L, 0), "reset");
        step(L, H, L, L, 2'b00, mk(L, L, L, 0), "reset_entry_ignored");

        // Three entries
        for (int i = 1; i <= 3; i++)
            step(H, H, L, L, 2'b00, mk(L, L, L, i), "entry_count");

        // Good exit: WAIT_CODE, OPEN held, CLOSE with decrement, IDLE
        step(H, L, H, L, 2'b00, mk(L, L, H, 3), "exit_wait");
        step(H, L, H, H, 2'b10, mk(H, H, L, 3), "exit_open");
        for (int i = 0; i < 3; i++)
            step(H, L, H, L, 2'b00, mk(H, H, L, 3), "exit_open_hold");
        step(H, L, L, L, 2'b00, mk(L, L, L, 2), "exit_close_dec");
        step(H, L, L, L, 2'b00, mk(L, L, L, 2), "exit_idle");

        // Three wrong codes -> LOCKOUT (correct code ignored there)
        step(H, L, H, L, 2'b00, mk(L, L, H, 2), "wrong_wait");
        for (int t = 1; t <= 2; t++) begin
            step(H, L, H, H, 2'b01, mk(L, L, H, 2), "wrong_code");
            step(H, L, H, L, 2'b00, mk(L, L, H, 2), "wrong_back_to_wait");
        end
        step(H, L, H, H, 2'b01, mk(L, L, H, 2), "wrong_code3");
        step(H, L, H, H, 2'b10, mk(L, L, L, 2), "lockout_enter");
        for (int i = 1; i <= 31; i++)
            step(H, L, H, H, 2'b10, mk(L, L, logic'(i & 1), 2), "lockout_toggle");
        step(H, L, L, H, 2'b10, mk(L, L, L, 2), "lockout_exit_idle");
        // Try counter must have cleared: one wrong code returns to WAIT_CODE
        step(H, L, H, L, 2'b00, mk(L, L, H, 2), "post_lock_wait");
        step(H, L, H, H, 2'b01, mk(L, L, H, 2), "post_lock_wrong");
        step(H, L, H, L, 2'b00, mk(L, L, H, 2), "post_lock_no_lockout");
        step(H, L, L, L, 2'b00, mk(L, L, L, 2), "sensor_drop_idle");

        // Fill to capacity, extra entry dropped
        for (int i = 3; i <= 9; i++)
            step(H, H, L, L, 2'b00, mk(L, L, L, i), "fill");
        step(H, H, L, L, 2'b00, mk(L, L, L, 9), "full_entry_dropped");

        // Exit while full with coincident entry: entry dropped, count drops
        step(H, L, H, L, 2'b00, mk(L, L, H, 9), "full_exit_wait");
        step(H, L, H, H, 2'b10, mk(H, H, L, 9), "full_exit_open");
        step(H, H, L, L, 2'b00, mk(L, L, L, 8), "full_exit_entry_dropped");
        step(H, L, L, L, 2'b00, mk(L, L, L, 8), "full_exit_idle");

        // Exit with coincident entry below capacity: count unchanged
        step(H, L, H, L, 2'b00, mk(L, L, H, 8), "coinc_wait");
        step(H, L, H, H, 2'b10, mk(H, H, L, 8), "coinc_open");
        step(H, H, L, L, 2'b00, mk(L, L, L, 8), "coinc_inc_dec");
        step(H, L, L, L, 2'b00, mk(L, L, L, 8), "coinc_idle");

        // Timeout: 16 cycles in WAIT_CODE, gate never opens
        step(H, L, H, L, 2'b00, mk(L, L, H, 8), "tmo_wait");
        for (int i = 1; i <= 15; i++)
            step(H, L, H, L, 2'b00, mk(L, L, H, 8), "tmo_waiting");
        step(H, L, H, L, 2'b00, mk(L, L, L, 8), "tmo_to_idle");
        step(H, L, L, L, 2'b00, mk(L, L, L, 8), "tmo_idle");

        // Code on the timeout cycle wins
        step(H, L, H, L, 2'b00, mk(L, L, H, 8), "prio_wait");
        for (int i = 1; i <= 15; i++)
            step(H, L, H, L, 2'b00, mk(L, L, H, 8), "prio_waiting");
        step(H, L, H, H, 2'b10, mk(H, H, L, 8), "prio_code_over_timeout");
        step(H, L, H, L, 2'b00, mk(H, H, L, 8), "prio_open_hold");

        // Reset while OPEN, then phantom car on an empty lot
        step(L, L, H, L, 2'b00, mk(L, L, L, 0), "reset_in_open");
        step(H, L, H, L, 2'b00, mk(L, L, H, 0), "phantom_red");
        step(H, L, H, L, 2'b00, mk(L, L, H, 0), "phantom_red_again");
        step(H, L, L, L, 2'b00, mk(L, L, L, 0), "phantom_clear");
        step(H, H, L, L, 2'b00, mk(L, L, L, 1), "after_reset_entry");
        step(H, L, H, L, 2'b00, mk(L, L, H, 1), "after_reset_wait");

        repeat (2) @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
